// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA scan sequencer with a pixel-enable divider,
// sync/blank decode and a vblank-scheduled game-update request/done handshake.
// Optional build macro VGA_SYNC_PIPE_EN: delays HSYNC/VSYNC/VIDEO_ON by one
// pixel so they line up with a one-stage registered renderer lookup.
module vga_timing_ctrl #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       upd_done_i,
  output logic       pix_tick_o,
  output logic [9:0] pix_x_o,
  output logic [9:0] pix_y_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic       frame_start_o,
  output logic       upd_req_o,
  output logic       overrun_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CW      = 10;
  localparam int unsigned DW      = $clog2(DIV);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic          fs_q, fs_d;
  logic [0:0]    state_q, state_d;
  logic          ovr_q, ovr_d;
  logic          line_end, frame_end, vblank_start;

  // Scan position events, all qualified by the pixel tick
  assign line_end     = tick_q && (x_q == CW'(H_TOTAL - 1));
  assign frame_end    = line_end && (y_q == CW'(V_TOTAL - 1));
  assign vblank_start = line_end && (y_q == CW'(V_ACTIVE - 1));

  // Divider, scan counters and decode; decodes only move with the counters,
  // so the first pixel after reset/enable reads as blanked
  always_comb begin
    div_d  = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
    tick_d = (div_d == DW'(DIV - 1));
    x_d    = x_q;
    y_d    = y_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    von_d  = von_q;
    fs_d   = frame_end;
    if (tick_q) begin
      if (line_end) begin
        x_d = '0;
        y_d = frame_end ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
      hs_d  = !((x_d >= CW'(H_ACTIVE + H_FRONT)) &&
                (x_d <  CW'(H_ACTIVE + H_FRONT + H_SYNC)));
      vs_d  = !((y_d >= CW'(V_ACTIVE + V_FRONT)) &&
                (y_d <  CW'(V_ACTIVE + V_FRONT + V_SYNC)));
      von_d = (x_d < CW'(H_ACTIVE)) && (y_d < CW'(V_ACTIVE));
    end
  end

  // Update handshake next-state: done has priority over the frame-wrap overrun
  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    if (state_q == ST_IDLE) begin
      if (vblank_start) state_d = ST_REQ;
    end else begin
      if (upd_done_i) begin
        state_d = ST_IDLE;
      end else if (frame_end) begin
        state_d = ST_IDLE;
        ovr_d   = 1'b1;
      end
    end
  end

  // State registers; EN low behaves as a synchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      von_q   <= 1'b0;
      fs_q    <= 1'b0;
      state_q <= ST_IDLE;
      ovr_q   <= 1'b0;
    end else if (!en_i) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      von_q   <= 1'b0;
      fs_q    <= 1'b0;
      state_q <= ST_IDLE;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      von_q   <= von_d;
      fs_q    <= fs_d;
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  logic hs_p_q, vs_p_q, von_p_q;

  // One-pixel delay of the sync/blank decode to match the renderer pipeline
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      von_p_q <= 1'b0;
    end else if (!en_i) begin
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      von_p_q <= 1'b0;
    end else if (tick_q) begin
      hs_p_q  <= hs_q;
      vs_p_q  <= vs_q;
      von_p_q <= von_q;
    end
  end

  assign hsync_o    = hs_p_q;
  assign vsync_o    = vs_p_q;
  assign video_on_o = von_p_q;
`else
  assign hsync_o    = hs_q;
  assign vsync_o    = vs_q;
  assign video_on_o = von_q;
`endif

  assign pix_tick_o    = tick_q;
  assign pix_x_o       = x_q;
  assign pix_y_o       = y_q;
  assign frame_start_o = fs_q;
  assign upd_req_o     = (state_q == ST_REQ);
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of vga_timing_ctrl on a shrunken
// 15x11-pixel raster (DIV=4) so full frames fit in a short run.
module tb_vga_timing_ctrl;

  localparam int DIV = 4;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FRAME = HT * VT * DIV;    // 660 CLK
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n, en, upd_done;
  logic       pix_tick, hsync, vsync, video_on, frame_start, upd_req, overrun;
  logic [9:0] pix_x, pix_y;

  int n_vec = 0;
  int n_err = 0;
  int e = 0;          // active clock edges since reset release / EN rise
  int hs_cnt = 0, vs_cnt = 0, von_cnt = 0;
  int last_fs = -1;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .upd_done_i(upd_done),
    .pix_tick_o(pix_tick), .pix_x_o(pix_x), .pix_y_o(pix_y),
    .hsync_o(hsync), .vsync_o(vsync), .video_on_o(video_on),
    .frame_start_o(frame_start), .upd_req_o(upd_req), .overrun_o(overrun)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Expected scan state is a closed-form function of the edge count
  task automatic check_scan(input int req_e, input int ovr_e);
    int p, ex, ey, etick, ehs, evs, evon, efs;
    p     = e / DIV;
    ex    = p % HT;
    ey    = (p / HT) % VT;
    etick = int'((e % DIV) == DIV - 1);
    ehs   = int'(!(ex >= HA + HF && ex < HA + HF + HS));
    evs   = int'(!(ey >= VA + VF && ey < VA + VF + VS));
    evon  = int'(p > 0 && ex < HA && ey < VA);
    efs   = int'((e % DIV) == 0 && p > 0 && (p % (HT * VT)) == 0);
    chk("pix_tick", int'(pix_tick), etick);
    chk("pix_x", int'(pix_x), ex);
    chk("pix_y", int'(pix_y), ey);
    chk("hsync", int'(hsync), ehs);
    chk("vsync", int'(vsync), evs);
    chk("video_on", int'(video_on), evon);
    chk("frame_start", int'(frame_start), efs);
    chk("upd_req", int'(upd_req), req_e);
    chk("overrun", int'(overrun), ovr_e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
    if (e >= FRAME && e < 2 * FRAME) begin
      if (!hsync)  hs_cnt++;
      if (!vsync)  vs_cnt++;
      if (video_on) von_cnt++;
    end
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_gap", e - last_fs, FRAME);
      last_fs = e;
    end
  endtask

  // Run to edge 'stop'; upd_req expected in [r0,r1), overrun from o0;
  // UPD_DONE is high for the one cycle after edge done_at
  task automatic run(input int stop, input int r0, input int r1,
                     input int o0, input int done_at);
    while (e < stop) begin
      step();
      upd_done = (e == done_at);
      check_scan(int'(e >= r0 && e < r1), int'(e >= o0));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    upd_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_scan(0, 0);
    end
    rst_n = 1'b1;
    e = 0;

    // Frame 1: request at (0,VA), done after 140 CLK, clean release
    run(FRAME, 360, 501, NEVER, 500);
    // Frame 2: no done -> overrun at the wrap, request drops
    run(2 * FRAME + 80, 1020, 1320, 1320, -1);
    chk("hsync_low_clks", hs_cnt, 132);
    chk("vsync_low_clks", vs_cnt, 60);
    chk("video_on_clks", von_cnt, 192);
    // Frame 3: overrun stays sticky while a new request opens
    run(1700, 1680, NEVER, 1320, -1);

    // EN low mid-frame: idle values, handshake aborted, overrun cleared
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      e = 0;
      check_scan(0, 0);
    end
    en = 1'b1;
    e = 0;
    last_fs = -1;

    // Restart from (0,0); done coincides with the wrap and wins
    run(FRAME + 40, 360, 660, NEVER, 659);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequences the 640x480@60 Hz VGA scan-out from the 100 MHz board clock. It derives a single-cycle pixel-enable tick (divide-by-4, 25 MHz), runs the horizontal and vertical scan counters, and decodes sync, blanking and pixel coordinates for the renderer. It also schedules the Pacman game-logic update into vertical blank through a request/done handshake, and flags updates that overrun the blank.

## Interface
- DIV, 4, CLK cycles per pixel tick (>= 2)
- H_ACTIVE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal region lengths in pixels
- V_ACTIVE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical region lengths in lines
- Derived: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525); both must be <= 1024
- CLK  in  1  100 MHz system clock; all logic on posedge
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  scan enable; low holds the block in idle
- UPD_DONE  in  1  game logic finished its frame update
- PIX_TICK  out  1  one-CLK pulse every DIV cycles
- PIX_X  out  10  horizontal counter, 0..H_TOTAL-1
- PIX_Y  out  10  vertical counter, 0..V_TOTAL-1
- HSYNC  out  1  active-low horizontal sync
- VSYNC  out  1  active-low vertical sync
- VIDEO_ON  out  1  high inside the active 640x480 window
- FRAME_START  out  1  one-CLK pulse at frame wrap
- UPD_REQ  out  1  update window open
- OVERRUN  out  1  sticky: update missed its window

## Operation
- Reset (RST_N low, async): the divider, PIX_X and PIX_Y go to 0, HSYNC=1, VSYNC=1, VIDEO_ON=0, PIX_TICK=0, FRAME_START=0, UPD_REQ=0, OVERRUN=0.
- EN low (synchronous): same values as reset, held while low. A high EN restarts from divider 0.
- Divider: counts 0..DIV-1 while EN is high. PIX_TICK=1 during the cycle the count equals DIV-1.
- Scan: on each CLK edge where PIX_TICK is high, PIX_X increments.
  - When PIX_X is H_TOTAL-1, it wraps to 0 and PIX_Y increments.
  - When PIX_Y is V_TOTAL-1 at that wrap, PIX_Y also wraps to 0.
- Decode: all decoded outputs are registered and update on the same edge as the counters, so they are consistent with PIX_X/PIX_Y.
  - HSYNC=0 iff H_ACTIVE+H_FRONT <= PIX_X < H_ACTIVE+H_FRONT+H_SYNC.
  - VSYNC=0 iff V_ACTIVE+V_FRONT <= PIX_Y < V_ACTIVE+V_FRONT+V_SYNC.
  - VIDEO_ON=1 iff PIX_X < H_ACTIVE and PIX_Y < V_ACTIVE.
- FRAME_START: high for the one CLK cycle after the counters become (0,0).
- Update FSM, states IDLE and REQ:
  - IDLE -> REQ on the edge where the counters become (0, V_ACTIVE). UPD_REQ=1 in REQ.
  - REQ -> IDLE on the edge after UPD_DONE is sampled high.
  - REQ -> IDLE with OVERRUN set when the counters wrap to (0,0) while still in REQ.
  - If UPD_DONE is high on the same edge as the wrap, done wins and OVERRUN is not set.
  - UPD_DONE is ignored in IDLE.
  - OVERRUN clears only on reset or EN low.

## Timing
- PIX_TICK period: DIV CLK cycles. The first tick after reset release or EN rise comes at CLK cycle DIV.
- Line: H_TOTAL*DIV = 3200 CLK. Frame: 525*3200 = 1,680,000 CLK.
- Latency: decoded outputs lag their counter value by 0 cycles. FRAME_START lags the (0,0) transition by 0 cycles; it is valid in the first cycle of pixel (0,0).
- UPD_REQ fall: 1 CLK after UPD_DONE is sampled high.
- Update window: V_FRONT+V_SYNC+V_BACK = 45 lines = 144,000 CLK.
- Reset or EN drop mid-frame: the handshake aborts with no OVERRUN. The counters restart at (0,0).

## Configuration
- VGA_SYNC_PIPE_EN defined:
  - HSYNC, VSYNC and VIDEO_ON pass through one extra register stage, advanced on PIX_TICK.
  - They therefore lag PIX_X/PIX_Y by exactly one pixel (DIV CLK), matching the renderer's one-stage registered tile/RGB lookup.
  - Their reset and EN-low values are unchanged.
- VGA_SYNC_PIPE_EN undefined: HSYNC, VSYNC and VIDEO_ON are aligned with PIX_X/PIX_Y as in Operation. FRAME_START and the update FSM are never delayed.

## Test plan
- Release RST_N with EN=1 -> first PIX_TICK at CLK 4, then every 4 CLK. All outputs held at reset values before release.
- Run one line -> HSYNC low for 384 CLK, starting at PIX_X=656. VIDEO_ON high for PIX_X 0..639. PIX_X wraps 799->0.
- Run two frames -> FRAME_START pulses exactly 1,680,000 CLK apart. VSYNC low for PIX_Y 490..491 (6400 CLK).
- At PIX_Y 480, UPD_REQ rises; pulse UPD_DONE 1000 CLK later -> UPD_REQ falls on the next CLK and OVERRUN stays 0.
- Hold UPD_DONE=0 through vblank -> OVERRUN=1 at the (0,0) wrap and UPD_REQ drops. OVERRUN persists across frames until EN is toggled low.
- Drop EN at PIX_Y=200 for 10 CLK, then raise it -> outputs return to idle values. Counters restart at (0,0), and PIX_TICK resumes 4 CLK after the EN rise.
